// File: rtl/lfsr_crypto_engine_if.sv
// Configuration, input-stream and output-stream signals of the LFSR crypto engine.
// The master side (driver) configures and feeds bytes; the slave side is the engine.
interface lfsr_crypto_engine_if #(
  parameter int W  = 8,
  parameter int PW = 6
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_mode;
  logic [W-1:0]  cfg_taps;
  logic [W-1:0]  cfg_seed;
  logic [PW-1:0] cfg_pre_len;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;

  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;

  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output cfg_valid, cfg_mode, cfg_taps, cfg_seed, cfg_pre_len,
    input  cfg_ready,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_data, out_last,
    output out_ready,
    input  busy, done, err
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_taps, cfg_seed, cfg_pre_len,
    output cfg_ready,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_data, out_last,
    input  out_ready,
    output busy, done, err
  );
endinterface

// File: rtl/lfsr_crypto_engine.sv
// Frame-based LFSR stream cipher: encrypts a message into a padded fixed-length frame,
// or recovers the keystream from the first cipher byte and decrypts a frame.
module lfsr_crypto_engine #(
  parameter int           W         = 8,
  parameter int           FRAME_LEN = 64,
  parameter int           MSG_LEN   = 41,
  parameter logic [W-1:0] PAD_CHAR  = W'(8'h20),
  parameter int           PW        = $clog2(FRAME_LEN)
) (
  input logic                 CLK,
  input logic                 start,
  lfsr_crypto_engine_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, EPRE, EBODY, EPOST, DSEED, DPRE, DBODY, DPOST, DONE
  } state_t;

  localparam logic [PW-1:0] MAX_PRE  = PW'(FRAME_LEN - MSG_LEN);
  localparam logic [PW-1:0] LAST_IDX = PW'(FRAME_LEN - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  lfsr_q, lfsr_d;
  logic [W-1:0]  taps_q, taps_d;
  logic [PW-1:0] preLen_q, preLen_d;
  logic [PW-1:0] idx_q, idx_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          outValid_q, outValid_d;
  logic [W-1:0]  outData_q, outData_d;
  logic          outLast_q, outLast_d;

  logic          cfgReady, inReady, canOut;
  logic          emit, emitLast, advance;
  logic [W-1:0]  emitData, stepSrc;
  logic [PW-1:0] preSat, preEnd, bodyEnd;

  assign canOut  = !outValid_q || bus.out_ready;
  assign preSat  = (bus.cfg_pre_len > MAX_PRE) ? MAX_PRE : bus.cfg_pre_len;
  assign preEnd  = preLen_q - PW'(1);
  assign bodyEnd = preLen_q + PW'(MSG_LEN - 1);

  // State register; start overrides every handshake and abandons any partial frame.
  always_ff @(posedge CLK) begin
    if (start) begin
      state_q    <= IDLE;
      lfsr_q     <= '0;
      taps_q     <= '0;
      preLen_q   <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outLast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      taps_q     <= taps_d;
      preLen_q   <= preLen_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      done_q     <= done_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outLast_q  <= outLast_d;
    end
  end

  // Next-state logic: each stage decides whether it consumes/produces a byte this cycle,
  // and the shared tail below loads the output register and steps the LFSR and byte index.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    taps_d     = taps_q;
    preLen_d   = preLen_q;
    idx_d      = idx_q;
    err_d      = err_q;
    done_d     = 1'b0;
    outValid_d = outValid_q && !bus.out_ready;
    outData_d  = outData_q;
    outLast_d  = outValid_d ? outLast_q : 1'b0;
    cfgReady   = 1'b0;
    inReady    = 1'b0;
    emit       = 1'b0;
    emitData   = '0;
    emitLast   = 1'b0;
    advance    = 1'b0;
    stepSrc    = lfsr_q;

    case (state_q)
      IDLE: begin
        cfgReady = 1'b1;
        if (bus.cfg_valid) begin
          taps_d = bus.cfg_taps;
          idx_d  = '0;
          err_d  = 1'b0;
          if (!bus.cfg_mode) begin
            lfsr_d   = bus.cfg_seed;
            preLen_d = preSat;
            state_d  = (preSat == '0) ? EBODY : EPRE;
          end else begin
            // The decrypt keystream is recovered from the first cipher byte, which is always padding.
            lfsr_d   = '0;
            preLen_d = (preSat == '0) ? PW'(1) : preSat;
            state_d  = DSEED;
          end
        end
      end
      EPRE: begin
        if (canOut) begin
          emit     = 1'b1;
          emitData = PAD_CHAR ^ lfsr_q;
          advance  = 1'b1;
          if (idx_q == preEnd) state_d = EBODY;
        end
      end
      EBODY: begin
        inReady = canOut;
        if (bus.in_valid && canOut) begin
          emit     = 1'b1;
          emitData = bus.in_data ^ lfsr_q;
          emitLast = (idx_q == LAST_IDX);
          advance  = 1'b1;
          if (idx_q == bodyEnd) state_d = (idx_q == LAST_IDX) ? DONE : EPOST;
        end
      end
      EPOST: begin
        if (canOut) begin
          emit     = 1'b1;
          emitData = PAD_CHAR ^ lfsr_q;
          emitLast = (idx_q == LAST_IDX);
          advance  = 1'b1;
          if (idx_q == LAST_IDX) state_d = DONE;
        end
      end
      DSEED: begin
        inReady = 1'b1;
        if (bus.in_valid) begin
          stepSrc = bus.in_data ^ PAD_CHAR;
          advance = 1'b1;
          state_d = (preLen_q == PW'(1)) ? DBODY : DPRE;
        end
      end
      DPRE: begin
        inReady = 1'b1;
        if (bus.in_valid) begin
          if ((bus.in_data ^ lfsr_q) != PAD_CHAR) err_d = 1'b1;
          advance = 1'b1;
          if (idx_q == preEnd) state_d = DBODY;
        end
      end
      DBODY: begin
        inReady = canOut;
        if (bus.in_valid && canOut) begin
          emit     = 1'b1;
          emitData = bus.in_data ^ lfsr_q;
          emitLast = (idx_q == bodyEnd);
          advance  = 1'b1;
          if (idx_q == bodyEnd) state_d = (idx_q == LAST_IDX) ? DONE : DPOST;
        end
      end
      DPOST: begin
        inReady = 1'b1;
        if (bus.in_valid) begin
          advance = 1'b1;
          if (idx_q == LAST_IDX) state_d = DONE;
        end
      end
      DONE: begin
        if (canOut) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      outValid_d = 1'b1;
      outData_d  = emitData;
      outLast_d  = emitLast;
    end
    if (advance) begin
      lfsr_d = {stepSrc[W-2:0], ^(stepSrc & taps_q)};
      idx_d  = idx_q + PW'(1);
    end
  end

  assign bus.cfg_ready = cfgReady;
  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.out_last  = outLast_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_lfsr_crypto_engine.sv
// Self-checking bench for lfsr_crypto_engine: table-driven and random frames checked
// against a frame-level keystream model, plus reset and reset-recovery sequences.
module tb_lfsr_crypto_engine;

  localparam int         W         = 8;
  localparam int         FRAME_LEN = 64;
  localparam int         MSG_LEN   = 41;
  localparam int         PW        = 6;
  localparam int         MAX_PRE   = FRAME_LEN - MSG_LEN;
  localparam logic [7:0] PAD       = 8'h20;

  typedef struct {
    logic       mode;
    logic [7:0] taps;
    logic [7:0] seed;
    logic [5:0] preLen;
    int         readyPct;
    int         corruptIdx;
    int         effPre;
    logic       expErr;
  } vec_t;

  logic clk;
  logic start;

  lfsr_crypto_engine_if #(.W(W), .PW(PW)) bus ();

  lfsr_crypto_engine #(
    .W(W), .FRAME_LEN(FRAME_LEN), .MSG_LEN(MSG_LEN), .PAD_CHAR(PAD), .PW(PW)
  ) dut (
    .CLK(clk),
    .start(start),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks;
  int         passes;
  logic [7:0] msg   [MSG_LEN];
  logic [7:0] frame [FRAME_LEN];
  logic [7:0] stim  [FRAME_LEN];
  logic [7:0] got   [$];
  logic       gotLast [$];
  vec_t       vecs  [10];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Keystream rule written arithmetically: shift left one place, feed in the tap parity.
  function automatic logic [7:0] modelStep(input logic [7:0] s, input logic [7:0] t);
    int v;
    v = (int'(s) * 2) % 256 + ($countones(s & t) % 2);
    return 8'(v);
  endfunction

  task automatic buildFrame(input logic [7:0] taps, input logic [7:0] seed, input int effPre);
    logic [7:0] s;
    logic [7:0] plain;
    s = seed;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i < effPre || i >= effPre + MSG_LEN) plain = PAD;
      else plain = msg[i - effPre];
      frame[i] = plain ^ s;
      s = modelStep(s, taps);
    end
  endtask

  task automatic fillMsg();
    for (int i = 0; i < MSG_LEN; i++) msg[i] = 8'($urandom);
  endtask

  task automatic checkResetState();
    checkOutput("reset cfg_ready", 32'(bus.cfg_ready), 32'd1);
    checkOutput("reset in_ready",  32'(bus.in_ready),  32'd0);
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset out_data",  32'(bus.out_data),  32'd0);
    checkOutput("reset out_last",  32'(bus.out_last),  32'd0);
    checkOutput("reset busy",      32'(bus.busy),      32'd0);
    checkOutput("reset done",      32'(bus.done),      32'd0);
    checkOutput("reset err",       32'(bus.err),       32'd0);
  endtask

  // Reset is held across a pending cfg handshake so its priority is exercised too.
  task automatic applyReset();
    @(negedge clk);
    start           = 1'b1;
    bus.cfg_valid   = 1'b1;
    bus.cfg_mode    = 1'b0;
    bus.cfg_taps    = 8'hff;
    bus.cfg_seed    = 8'h55;
    bus.cfg_pre_len = 6'd3;
    bus.in_valid    = 1'b1;
    bus.in_data     = 8'h00;
    bus.out_ready   = 1'b0;
    @(negedge clk);
    #1;
    checkResetState();
    start         = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.in_valid  = 1'b0;
  endtask

  // Runs one frame with randomised handshakes; abortAt >= 0 stops after that many outputs.
  task automatic applyStimulus(input vec_t v, input int abortAt);
    int         stimLen, ptr, cyc, firstOut, lastOut, doneCyc, stallErr, errPtr, mism, lastBad, expLen;
    logic       finished, prevStall, errAtEnd;
    logic [7:0] prevData;

    buildFrame(v.taps, v.seed, v.effPre);
    if (!v.mode) begin
      stimLen = MSG_LEN;
      for (int i = 0; i < MSG_LEN; i++) stim[i] = msg[i];
    end else begin
      stimLen = FRAME_LEN;
      for (int i = 0; i < FRAME_LEN; i++) stim[i] = frame[i];
      if (v.corruptIdx >= 0) stim[v.corruptIdx] = stim[v.corruptIdx] ^ 8'h01;
    end
    got.delete();
    gotLast.delete();

    @(negedge clk);
    bus.cfg_valid   = 1'b1;
    bus.cfg_mode    = v.mode;
    bus.cfg_taps    = v.taps;
    bus.cfg_seed    = v.mode ? 8'($urandom) : v.seed;
    bus.cfg_pre_len = v.preLen;
    #1;
    checkOutput("cfg_ready in idle", 32'(bus.cfg_ready), 32'd1);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    #1;
    checkOutput("busy after cfg", 32'(bus.busy), 32'd1);
    checkOutput("err cleared by cfg", 32'(bus.err), 32'd0);

    ptr = 0; cyc = 0; firstOut = -1; lastOut = -1; doneCyc = -1;
    stallErr = 0; errPtr = -1; finished = 1'b0; prevStall = 1'b0;
    prevData = '0; errAtEnd = 1'b0;
    while (!finished && cyc < 2000) begin
      bus.cfg_valid = 1'b0;
      bus.out_ready = ($urandom_range(99) < 32'(v.readyPct));
      if (ptr < stimLen) begin
        bus.in_valid = (v.readyPct == 100) ? 1'b1 : ($urandom_range(3) != 0);
        bus.in_data  = stim[ptr];
      end else begin
        bus.in_valid = 1'($urandom_range(1));
        bus.in_data  = 8'($urandom);
      end
      #1;
      if (bus.busy && $urandom_range(3) == 0) begin
        bus.cfg_valid   = 1'b1;
        bus.cfg_mode    = ~v.mode;
        bus.cfg_taps    = 8'($urandom);
        bus.cfg_pre_len = 6'($urandom);
      end
      if (prevStall && (!bus.out_valid || bus.out_data !== prevData)) stallErr++;
      prevStall = bus.out_valid && !bus.out_ready;
      prevData  = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        got.push_back(bus.out_data);
        gotLast.push_back(bus.out_last);
        if (firstOut < 0) firstOut = cyc;
        lastOut = cyc;
      end
      if (bus.err && errPtr < 0) errPtr = ptr;
      if (bus.in_valid && bus.in_ready) ptr++;
      if (bus.done) begin
        doneCyc  = cyc;
        errAtEnd = bus.err;
        finished = 1'b1;
      end
      if (abortAt >= 0 && got.size() == abortAt) break;
      @(negedge clk);
      cyc++;
    end

    if (abortAt < 0) begin
      bus.cfg_valid = 1'b0;
      bus.in_valid  = 1'b0;
      checkOutput("frame completes", 32'(finished), 32'd1);
      expLen = v.mode ? MSG_LEN : FRAME_LEN;
      checkOutput("output count", 32'(got.size()), 32'(expLen));
      mism = 0; lastBad = 0;
      for (int i = 0; i < got.size() && i < expLen; i++) begin
        if (got[i] !== (v.mode ? msg[i] : frame[i])) begin
          if (mism == 0) $display("[TB] FAIL byte %0d: got %0h, expected %0h", i, got[i], v.mode ? msg[i] : frame[i]);
          mism++;
        end
        if (gotLast[i] !== (i == expLen - 1)) lastBad++;
      end
      checkOutput("output bytes wrong", 32'(mism), 32'd0);
      checkOutput("out_last placement", 32'(lastBad), 32'd0);
      checkOutput("stall hold violations", 32'(stallErr), 32'd0);
      checkOutput("err at frame end", 32'(errAtEnd), 32'(v.expErr));
      if (v.corruptIdx >= 0) checkOutput("err onset byte count", 32'(errPtr), 32'(v.corruptIdx + 1));
      if (!v.mode) checkOutput("done cycles after last", 32'(doneCyc - lastOut), 32'd1);
      if (v.readyPct == 100) checkOutput("burst span", 32'(lastOut - firstOut), 32'(got.size() - 1));
      @(negedge clk);
      #1;
      checkOutput("done single pulse", 32'(bus.done), 32'd0);
      checkOutput("idle after frame", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks          = 0;
    passes          = 0;
    start           = 1'b1;
    bus.cfg_valid   = 1'b0;
    bus.cfg_mode    = 1'b0;
    bus.cfg_taps    = '0;
    bus.cfg_seed    = '0;
    bus.cfg_pre_len = '0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b0;
    applyReset();
    fillMsg();

    vecs[0] = '{1'b0, 8'hd4, 8'h41, 6'd9,  100, -1, 9,  1'b0};
    vecs[1] = '{1'b1, 8'hd4, 8'h41, 6'd9,  100, -1, 9,  1'b0};
    vecs[2] = '{1'b1, 8'hd4, 8'h41, 6'd9,  100,  3, 9,  1'b1};
    vecs[3] = '{1'b0, 8'hd4, 8'h41, 6'd9,  50,  -1, 9,  1'b0};
    vecs[4] = '{1'b0, 8'hd4, 8'h41, 6'd60, 100, -1, 23, 1'b0};
    vecs[5] = '{1'b1, 8'hd4, 8'h41, 6'd60, 60,  -1, 23, 1'b0};
    vecs[6] = '{1'b0, 8'hb8, 8'h00, 6'd5,  70,  -1, 5,  1'b0};
    vecs[7] = '{1'b0, 8'h8e, 8'h5a, 6'd0,  100, -1, 0,  1'b0};
    vecs[8] = '{1'b1, 8'h8e, 8'h5a, 6'd0,  50,  -1, 1,  1'b0};
    vecs[9] = '{1'b1, 8'hd4, 8'h41, 6'd9,  50,  -1, 9,  1'b0};

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], -1);

    // Reference frame: first two cipher bytes are fixed by taps d4 / seed 41.
    applyStimulus(vecs[0], -1);
    checkOutput("first cipher byte", 32'(got[0]), 32'h61);
    checkOutput("second cipher byte", 32'(got[1]), 32'ha3);

    // Abort an encrypt frame after 30 bytes, then show a fresh frame is complete and correct.
    applyStimulus(vecs[0], 30);
    applyReset();
    applyStimulus(vecs[3], -1);

    for (int r = 0; r < 6; r++) begin
      vec_t v;
      int   sat;
      fillMsg();
      v.mode     = 1'($urandom_range(1));
      v.taps     = 8'($urandom);
      v.seed     = 8'($urandom);
      v.preLen   = 6'($urandom_range(40));
      v.readyPct = $urandom_range(100, 30);
      sat        = (int'(v.preLen) > MAX_PRE) ? MAX_PRE : int'(v.preLen);
      if (v.mode && sat == 0) sat = 1;
      v.effPre     = sat;
      v.corruptIdx = -1;
      v.expErr     = 1'b0;
      if (v.mode && sat > 1 && $urandom_range(1) == 1) begin
        v.corruptIdx = $urandom_range(sat - 1, 1);
        v.expErr     = 1'b1;
      end
      applyStimulus(v, -1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_crypto_engine.md
LFSR_CRYPTO_ENGINE -- requirements
Module: lfsr_crypto_engine

Interface
REQ-001 Parameter W, default 8: data and LFSR width in bits.
REQ-002 Parameter FRAME_LEN, default 64: bytes per encrypted frame.
REQ-003 Parameter MSG_LEN, default 41: plaintext bytes per message.
REQ-004 Parameter PAD_CHAR, default 8'h20: preamble/postamble fill value.
REQ-005 Parameter PW, default $clog2(FRAME_LEN): width of pre_len and counters.
REQ-006 CLK  input  1  the single clock; all logic on rising edge.
REQ-007 start  input  1  synchronous active-high reset.
REQ-008 cfg_valid / cfg_ready  input / output  1 / 1  configuration handshake.
REQ-009 cfg_mode  input  1  0 = encrypt, 1 = decrypt.
REQ-010 cfg_taps  input  W  LFSR feedback tap mask.
REQ-011 cfg_seed  input  W  LFSR initial state; used in encrypt mode only.
REQ-012 cfg_pre_len  input  PW  number of pad bytes before the message.
REQ-013 in_valid / in_ready / in_data  input / output / input  1 / 1 / W  input byte stream.
REQ-014 out_valid / out_ready / out_data / out_last  output / input / output / output  1 / 1 / W / 1  output byte stream.
REQ-015 busy / done / err  output  1 each  frame active; one-cycle completion pulse; decrypt preamble mismatch (sticky).

Function
REQ-016 LFSR step SHALL be next = {s[W-2:0], ^(s & taps)}; one step per byte emitted in encrypt mode or consumed in decrypt mode.
REQ-017 cfg_ready SHALL be 1 only in IDLE; a cfg handshake latches mode, taps, seed and pre_len, then leaves IDLE.
REQ-018 pre_len SHALL saturate to FRAME_LEN-MSG_LEN; in decrypt mode, pre_len 0 SHALL be treated as 1.
REQ-019 A seed of 0 SHALL be legal; the keystream is then constant 0.
REQ-020 Encrypt states SHALL be IDLE -> EPRE -> EBODY -> EPOST -> DONE -> IDLE.
REQ-021 EPRE SHALL emit pre_len bytes of PAD_CHAR^s; in_ready = 0 throughout.
REQ-022 EBODY SHALL accept MSG_LEN input bytes and emit in_data^s for each.
REQ-023 EPOST SHALL emit PAD_CHAR^s until FRAME_LEN bytes total have been emitted; out_last marks byte FRAME_LEN-1.
REQ-024 Decrypt states SHALL be IDLE -> DSEED -> DPRE -> DBODY -> DPOST -> DONE -> IDLE.
REQ-025 DSEED: the first cipher byte c0 SHALL set the LFSR to c0^PAD_CHAR, then step once; this byte produces no output.
REQ-026 DPRE: the remaining pre_len-1 preamble bytes SHALL be consumed with no output; any byte where c^s != PAD_CHAR SHALL set err.
REQ-027 DBODY: SHALL output c^s for MSG_LEN bytes; out_last marks the last of them.
REQ-028 DPOST: SHALL consume and discard bytes until FRAME_LEN bytes total have been consumed.
REQ-029 Output register: one entry deep, registered; out_data/out_valid SHALL appear one cycle after the producing step.
REQ-030 Output register behaviour under backpressure:
- a stage needing the output register SHALL advance only when !out_valid || out_ready;
- in_ready SHALL be 0 whenever a required output cannot be taken.
REQ-031 out_data SHALL hold stable while out_valid && !out_ready.
REQ-032 Sustained throughput SHALL be 1 byte/cycle when out_ready = 1.
REQ-033 In DONE, after the final output is accepted, done SHALL pulse for 1 cycle, then the block returns to IDLE.
REQ-034 err SHALL clear on the next cfg handshake.
REQ-035 busy SHALL be 1 in every state except IDLE.
REQ-036 in_valid while in_ready = 0 SHALL be ignored; cfg_valid outside IDLE SHALL be ignored.

Reset
REQ-037 When start = 1 at a clock edge, the block SHALL enter IDLE from any state, including mid-frame; the partial frame is abandoned.
REQ-038 Reset values: cfg_ready=1, in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, err=0, LFSR=0, counters=0.
REQ-039 start SHALL take priority over every handshake in the same cycle.

Verification
REQ-040 Encrypt, taps=8'hd4, seed=8'h41, pre_len=9, out_ready=1 -> out bytes 0,1 = 8'h61, 8'hA3; 64 bytes total; out_last on byte 63; done 1 cycle later.
REQ-041 Decrypt the REQ-040 frame with taps=8'hd4, pre_len=9 -> 41 bytes equal the original plaintext; err=0.
REQ-042 Decrypt with cipher byte 3 corrupted (XOR 8'h01) -> err=1 after byte 3; body output unchanged; err clears on next cfg handshake.
REQ-043 Encrypt with out_ready random 50% -> output matches the REQ-040 sequence exactly; no byte dropped or duplicated; out_data stable while stalled.
REQ-044 cfg_pre_len=60 -> treated as 23; 23 pad bytes precede the body; frame length still 64.
REQ-045 start=1 at byte 30 of an encrypt frame -> next cycle in IDLE with all REQ-038 values; a new cfg then produces a correct full frame.
